// File: rtl/move_arbiter.sv
// Direction-button arbiter: turns button presses into one-hot move offers for the room FSM,
// filters moves against the current room, and counts accepted and rejected presses.
module move_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       N,
    input  logic       S,
    input  logic       E,
    input  logic       W,
    input  logic [2:0] room,
    input  logic       dir_ready,
    output logic       dir_valid,
    output logic [3:0] dir,
    output logic [7:0] move_count,
    output logic [3:0] illegal_count,
    output logic       game_over
);

    typedef enum logic [2:0] {
        StIdle,
        StOffer,
        StSettle1,
        StSettle2,
        StHalt
    } state_e;

    state_e     r_state;
    state_e     w_state_next;
    logic [3:0] r_prev;
    logic [3:0] r_pending;
    logic [3:0] w_pending_next;
    logic [3:0] r_dir;
    logic [3:0] w_dir_next;
    logic [7:0] r_move_cnt;
    logic [7:0] w_move_next;
    logic [3:0] r_ill_cnt;
    logic [3:0] w_ill_next;

    logic [3:0] w_btn;
    logic [3:0] w_edge;
    logic [3:0] w_allowed;
    logic [3:0] w_legal;
    logic [3:0] w_illegal;
    logic [3:0] w_pick;
    logic       w_terminal;

    assign w_btn      = {N, S, E, W};
    assign w_edge     = w_btn & ~r_prev;
    assign w_terminal = (room == 3'b101) || (room == 3'b110);
    assign w_legal    = r_pending & w_allowed;
    assign w_illegal  = r_pending & ~w_allowed;

    // Legal moves per room, bit order {N,S,E,W}
    always_comb begin
        w_allowed = 4'b0000;
        case (room)
            3'b000:  w_allowed = 4'b0100;
            3'b001:  w_allowed = 4'b0101;
            3'b010:  w_allowed = 4'b1011;
            3'b011:  w_allowed = 4'b0010;
            3'b100:  w_allowed = 4'b0011;
            default: w_allowed = 4'b0000;
        endcase
    end

    always_comb begin
        w_pick = 4'b0000;
        if (w_legal[3])      w_pick = 4'b1000;
        else if (w_legal[2]) w_pick = 4'b0100;
        else if (w_legal[1]) w_pick = 4'b0010;
        else if (w_legal[0]) w_pick = 4'b0001;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_terminal)          w_state_next = StHalt;
                else if (w_legal != '0)  w_state_next = StOffer;
            end
            StOffer:   if (dir_ready) w_state_next = StSettle1;
            StSettle1: w_state_next = StSettle2;
            StSettle2: w_state_next = StIdle;
            StHalt:    w_state_next = StHalt;
            default:   w_state_next = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        dir_valid     = (r_state == StOffer);
        dir           = (r_state == StOffer) ? r_dir : 4'b0000;
        game_over     = (r_state == StHalt);
        move_count    = r_move_cnt;
        illegal_count = r_ill_cnt;
    end

    // Datapath next values: pending, latched move and saturating counters
    always_comb begin
        w_pending_next = r_pending;
        w_dir_next     = r_dir;
        w_move_next    = r_move_cnt;
        w_ill_next     = r_ill_cnt;
        case (r_state)
            StIdle: begin
                if (w_terminal) begin
                    w_pending_next = r_pending | w_edge;
                end else begin
                    w_pending_next = w_legal | w_edge;
                    if (w_illegal != '0 && r_ill_cnt != 4'hF) w_ill_next = r_ill_cnt + 4'd1;
                    if (w_legal != '0) w_dir_next = w_pick;
                end
            end
            StOffer: begin
                if (dir_ready) begin
                    w_pending_next = 4'b0000;
                    if (r_move_cnt != 8'hFF) w_move_next = r_move_cnt + 8'd1;
                end else begin
                    w_pending_next = r_pending | w_edge;
                end
            end
            StSettle1, StSettle2: w_pending_next = r_pending | w_edge;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev     <= 4'b0000;
            r_pending  <= 4'b0000;
            r_dir      <= 4'b0000;
            r_move_cnt <= 8'd0;
            r_ill_cnt  <= 4'd0;
        end else begin
            r_prev     <= w_btn;
            r_pending  <= w_pending_next;
            r_dir      <= w_dir_next;
            r_move_cnt <= w_move_next;
            r_ill_cnt  <= w_ill_next;
        end
    end

endmodule
